// File: rtl/ks10_bus_pkg.sv
// Shared KS10 backplane definitions: address-word flag positions, field
// ranges and the IO responder state encoding.
package ks10_bus_pkg;

    // Flag bit positions in the big-endian [0:35] address word
    localparam int FLAG_READ   = 3;
    localparam int FLAG_WRITE  = 5;
    localparam int FLAG_IO     = 10;
    localparam int FLAG_WRU    = 11;
    localparam int FLAG_VECT   = 12;
    localparam int FLAG_IOBYTE = 13;

    localparam int CTL_FIRST  = 14;
    localparam int CTL_LAST   = 17;
    localparam int ADDR_FIRST = 18;
    localparam int ADDR_LAST  = 35;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2,
        ABORT  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/uba_bus_decode.sv
// Combinational address decode for an IO responder: checks the flag combination,
// controller number and register window, and yields the word index in the window.
module uba_bus_decode
    import ks10_bus_pkg::*;
#(
    parameter logic [3:0]  CTLNUM   = 4'd1,
    parameter logic [17:0] BASEADDR = 18'o763000,
    parameter int          NREGS    = 32
) (
    input  logic [0:35] busADDRI,
    output logic        match,
    output logic        isRead,
    output logic [7:0]  index
);

    localparam logic [18:0] BASE_EXT  = {1'b0, BASEADDR};
    localparam logic [18:0] LIMIT_EXT = BASE_EXT + 19'(NREGS);

    logic [3:0]  ctl;
    logic [17:0] addr;
    logic [17:0] offset;
    logic        rd_flag;
    logic        wr_flag;
    logic        in_window;
    logic        unused_bits;

    assign ctl     = busADDRI[CTL_FIRST:CTL_LAST];
    assign addr    = busADDRI[ADDR_FIRST:ADDR_LAST];
    assign rd_flag = busADDRI[FLAG_READ];
    assign wr_flag = busADDRI[FLAG_WRITE];

    // 19-bit compare so a window ending at the top of the space cannot wrap
    assign in_window = ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT_EXT);
    assign offset    = addr - BASEADDR;

    assign match  = busADDRI[FLAG_IO] && !busADDRI[FLAG_WRU] && !busADDRI[FLAG_VECT]
                    && (rd_flag ^ wr_flag) && (ctl == CTLNUM) && in_window;
    assign isRead = rd_flag;
    assign index  = offset[7:0];

    // Byte-write flag and the remaining flag bits have no effect on a word register
    assign unused_bits = ^{busADDRI[0:2], busADDRI[4], busADDRI[6:9],
                           busADDRI[FLAG_IOBYTE], offset[17:8]};

endmodule

// File: rtl/uba_bus_responder.sv
// Target-side KS10 backplane responder: accepts IO reads/writes for its register
// window, strobes the local device and returns the ack, or flags a device timeout.
module uba_bus_responder
    import ks10_bus_pkg::*;
#(
    parameter logic [3:0]  CTLNUM   = 4'd1,
    parameter logic [17:0] BASEADDR = 18'o763000,
    parameter int          NREGS    = 32,
    parameter int          MAXWAIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busREQI,
    input  logic [0:35] busADDRI,
    input  logic [35:0] busDATAI,
    output logic        busACKO,
    output logic [35:0] busDATAO,
    output logic        devREAD,
    output logic        devWRITE,
    output logic [7:0]  devADDR,
    output logic [35:0] devDATAO,
    input  logic [35:0] devDATAI,
    input  logic        devACK,
    output logic        devTMO
);

    resp_state_t state_reg;
    logic [3:0]  count_reg;
    logic        is_read_reg;

    logic        dec_match;
    logic        dec_is_read;
    logic [7:0]  dec_index;

    uba_bus_decode #(
        .CTLNUM   (CTLNUM),
        .BASEADDR (BASEADDR),
        .NREGS    (NREGS)
    ) u_decode (
        .busADDRI (busADDRI),
        .match    (dec_match),
        .isRead   (dec_is_read),
        .index    (dec_index)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            is_read_reg <= 1'b0;
            busACKO     <= 1'b0;
            busDATAO    <= '0;
            devREAD     <= 1'b0;
            devWRITE    <= 1'b0;
            devADDR     <= '0;
            devDATAO    <= '0;
            devTMO      <= 1'b0;
        end else begin
            // All strobes are single-cycle; only the entering transition raises them
            busACKO  <= 1'b0;
            busDATAO <= '0;
            devREAD  <= 1'b0;
            devWRITE <= 1'b0;
            devTMO   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (busREQI && dec_match) begin
                        devADDR     <= dec_index;
                        devDATAO    <= busDATAI;
                        is_read_reg <= dec_is_read;
                        count_reg   <= 4'(MAXWAIT);
                        devREAD     <= dec_is_read;
                        devWRITE    <= !dec_is_read;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the last allowed edge still wins over the timeout
                    if (devACK) begin
                        busACKO   <= 1'b1;
                        busDATAO  <= is_read_reg ? devDATAI : '0;
                        state_reg <= ACK;
                    end else if (count_reg == 4'd1) begin
                        devTMO    <= 1'b1;
                        state_reg <= ABORT;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                ACK:     state_reg <= IDLE;
                ABORT:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uba_bus_responder.sv
// Directed and randomized bench for uba_bus_responder, checked against a
// transaction-level timeline model of the responder's externally visible behaviour.
module tb_uba_bus_responder;

    localparam logic [17:0] BASE    = 18'o763000;
    localparam int          NREG    = 32;
    localparam int          MAXW    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busREQI = 1'b0;
    logic [0:35] busADDRI = '0;
    logic [35:0] busDATAI = '0;
    logic        busACKO;
    logic [35:0] busDATAO;
    logic        devREAD;
    logic        devWRITE;
    logic [7:0]  devADDR;
    logic [35:0] devDATAO;
    logic [35:0] devDATAI = '0;
    logic        devACK = 1'b0;
    logic        devTMO;

    int checks = 0;
    int failures = 0;
    int txn_no = 0;
    logic [7:0]  last_addr = '0;
    logic [35:0] last_wdata = '0;

    uba_bus_responder #(
        .CTLNUM   (4'd1),
        .BASEADDR (BASE),
        .NREGS    (NREG),
        .MAXWAIT  (MAXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .busREQI  (busREQI),
        .busADDRI (busADDRI),
        .busDATAI (busDATAI),
        .busACKO  (busACKO),
        .busDATAO (busDATAO),
        .devREAD  (devREAD),
        .devWRITE (devWRITE),
        .devADDR  (devADDR),
        .devDATAO (devDATAO),
        .devDATAI (devDATAI),
        .devACK   (devACK),
        .devTMO   (devTMO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] build_addr(input bit rd, input bit wr, input bit io,
                                               input bit wru, input bit vect, input bit iob,
                                               input logic [3:0] ctl, input logic [17:0] addr);
        logic [0:35] a;
        a = '0;
        a[3] = rd; a[5] = wr; a[10] = io; a[11] = wru; a[12] = vect; a[13] = iob;
        a[14:17] = ctl;
        a[18:35] = addr;
        return a;
    endfunction

    // Match rule stated directly from the bus protocol
    function automatic bit model_match(input bit rd, input bit wr, input bit io, input bit wru,
                                       input bit vect, input logic [3:0] ctl, input logic [17:0] addr);
        int a;
        a = int'(addr);
        return io && !wru && !vect && (rd != wr) && (ctl == 4'd1)
               && (a >= int'(BASE)) && (a < int'(BASE) + NREG);
    endfunction

    task automatic check_idle_outputs(input string where);
        chk({where, ".busACKO"}, 36'(busACKO), 36'd0);
        chk({where, ".devTMO"}, 36'(devTMO), 36'd0);
        chk({where, ".devREAD"}, 36'(devREAD), 36'd0);
        chk({where, ".devWRITE"}, 36'(devWRITE), 36'd0);
        chk({where, ".busDATAO"}, busDATAO, 36'd0);
    endtask

    // One bus transaction. d = number of ACCESS cycles the device waits before acking.
    task automatic do_txn(input bit rd, input bit wr, input bit io, input bit wru, input bit vect,
                          input bit iob, input logic [3:0] ctl, input logic [17:0] addr,
                          input logic [35:0] wdata, input logic [35:0] rdata, input int d,
                          input bit spurious);
        bit exp_match;
        bit acked;
        int end_cyc;
        int last;
        exp_match = model_match(rd, wr, io, wru, vect, ctl, addr);
        acked     = (d < MAXW);
        end_cyc   = acked ? d + 2 : MAXW + 1;
        last      = exp_match ? end_cyc : 3;

        @(negedge clk);
        check_idle_outputs("pre");
        busREQI  = 1'b1;
        busADDRI = build_addr(rd, wr, io, wru, vect, iob, ctl, addr);
        busDATAI = wdata;
        devACK   = 1'($urandom_range(0, 1));
        devDATAI = {4'($urandom), $urandom};
        if (exp_match) begin
            last_addr  = 8'(int'(addr) - int'(BASE));
            last_wdata = wdata;
        end

        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            if (spurious && exp_match && cyc == 1) begin
                busREQI  = 1'b1;
                busADDRI = build_addr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1,
                                      BASE + 18'($urandom_range(0, NREG - 1)));
                busDATAI = {4'($urandom), $urandom};
            end else begin
                busREQI = 1'b0;
            end
            devACK   = (exp_match && cyc < end_cyc) ? (cyc == d + 1) : 1'($urandom_range(0, 1));
            devDATAI = (exp_match && cyc == d + 1) ? rdata : {4'($urandom), $urandom};

            chk("devREAD", 36'(devREAD), 36'(exp_match && rd && cyc == 1));
            chk("devWRITE", 36'(devWRITE), 36'(exp_match && wr && cyc == 1));
            chk("busACKO", 36'(busACKO), 36'(exp_match && acked && cyc == d + 2));
            chk("busDATAO", busDATAO, (exp_match && acked && rd && cyc == d + 2) ? rdata : 36'd0);
            chk("devTMO", 36'(devTMO), 36'(exp_match && !acked && cyc == MAXW + 1));
            chk("devADDR", 36'(devADDR), 36'(last_addr));
            chk("devDATAO", devDATAO, last_wdata);
        end
        busREQI = 1'b0;
        devACK  = 1'b0;
        txn_no++;
        $display("txn %0d: rd=%0d wr=%0d io=%0d wru=%0d vect=%0d ctl=%0d addr=%o delay=%0d match=%0d checks=%0d",
                 txn_no, rd, wr, io, wru, vect, ctl, addr, d, exp_match, checks);
    endtask

    initial begin
        #3;
        check_idle_outputs("reset");
        chk("reset.devADDR", 36'(devADDR), 36'd0);
        chk("reset.devDATAO", devDATAO, 36'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: fastest read, delayed write, timeout, last-edge ack
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763004, 36'o0, 36'o123456701234, 0, 0);
        do_txn(0, 1, 1, 0, 0, 0, 4'd1, 18'o763010, 36'o777, 36'o555555555555, 5, 0);
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763004, 36'o1, 36'o2, MAXW + 2, 0);
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763037, 36'o3, 36'o707070707070, 0, 0);
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763001, 36'o4, 36'o606060606060, MAXW - 1, 0);
        do_txn(0, 1, 1, 0, 0, 1, 4'd1, 18'o763000, 36'o12345, 36'o0, MAXW - 1, 1);

        // Directed: requests that must be ignored
        do_txn(1, 0, 1, 0, 0, 0, 4'd3, 18'o763004, 36'o11, 36'o0, 0, 0);
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763040, 36'o22, 36'o0, 0, 0);
        do_txn(1, 1, 1, 0, 0, 0, 4'd1, 18'o763004, 36'o33, 36'o0, 0, 0);
        do_txn(1, 0, 1, 1, 0, 0, 4'd1, 18'o763004, 36'o44, 36'o0, 0, 0);
        do_txn(1, 0, 1, 0, 1, 0, 4'd1, 18'o763004, 36'o55, 36'o0, 0, 0);
        do_txn(1, 0, 0, 0, 0, 0, 4'd1, 18'o763004, 36'o66, 36'o0, 0, 0);
        do_txn(0, 1, 1, 0, 0, 0, 4'd1, 18'o762777, 36'o77, 36'o0, 0, 0);

        // Reset in the middle of an access
        @(negedge clk);
        busREQI  = 1'b1;
        busADDRI = build_addr(1, 0, 1, 0, 0, 0, 4'd1, 18'o763006);
        busDATAI = 36'o4444;
        @(negedge clk);
        busREQI = 1'b0;
        chk("rstmid.devREAD_before", 36'(devREAD), 36'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("rstmid");
        chk("rstmid.devADDR", 36'(devADDR), 36'd0);
        chk("rstmid.devDATAO", devDATAO, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        for (int i = 0; i < MAXW + 3; i++) begin
            @(negedge clk);
            chk("rstmid.devTMO_after", 36'(devTMO), 36'd0);
            chk("rstmid.busACKO_after", 36'(busACKO), 36'd0);
        end
        do_txn(1, 0, 1, 0, 0, 0, 4'd1, 18'o763006, 36'o5, 36'o101010101010, 2, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            bit rd, wr, io, wru, vect, iob;
            logic [3:0]  ctl;
            logic [17:0] addr;
            int sel;
            sel  = int'($urandom_range(0, 3));
            rd   = 1'($urandom_range(0, 1));
            wr   = (sel == 0) ? 1'($urandom_range(0, 1)) : !rd;
            io   = ($urandom_range(0, 9) != 0);
            wru  = ($urandom_range(0, 9) == 0);
            vect = ($urandom_range(0, 9) == 0);
            iob  = 1'($urandom_range(0, 1));
            ctl  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd1;
            addr = ($urandom_range(0, 7) == 0) ? 18'($urandom)
                                                : BASE - 18'd4 + 18'($urandom_range(0, NREG + 8));
            do_txn(rd, wr, io, wru, vect, iob, ctl, addr, {4'($urandom), $urandom},
                   {4'($urandom), $urandom}, int'($urandom_range(0, MAXW + 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
